mem_port_arbiter: RTL and testbench

- Parametrised N-port memory arbiter for the next-generation pipelined core: I-side and D-side (and optional extra masters) share one memory port.
- Each client port uses the same handshake the multicycle cpu drives: read/write/byte_enable/address/wdata in, rdata/resp out.
- Sits between the core and the cache/physical memory.
- Adds fixed-priority or round-robin arbitration, configurable widths and port count.

---
 rtl/mem_port_arbiter_pkg.sv | 14 +
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter_priority_pick.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter and its priority picker.
// Also holds the pointer-width helper used by both modules.
package arb_types;

  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_t;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  localparam int MAX_PORTS = 8;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Client-side and memory-side bus of the arbiter, grouped so one handle carries everything.
// Handshake: a client holds read/write/be/address/wdata stable while (read|write) is high
// until its port_resp pulse; the memory side holds mem_* stable until mem_resp is high.
interface mem_port_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0]                 port_read;
  logic [NUM_PORTS-1:0]                 port_write;
  logic [NUM_PORTS-1:0][BE_W-1:0]       port_byte_enable;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] port_address;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_wdata;
  logic [DATA_WIDTH-1:0]                port_rdata;
  logic [NUM_PORTS-1:0]                 port_resp;

  logic                  mem_read;
  logic                  mem_write;
  logic [BE_W-1:0]       mem_byte_enable;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  logic [NUM_PORTS-1:0]  grant;
  logic                  busy;

  modport slave (
    input  port_read, port_write, port_byte_enable, port_address, port_wdata,
    input  mem_rdata, mem_resp,
    output port_rdata, port_resp,
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output grant, busy
  );

  modport master (
    output port_read, port_write, port_byte_enable, port_address, port_wdata,
    output mem_rdata, mem_resp,
    input  port_rdata, port_resp,
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  grant, busy
  );

endinterface

// File: rtl/mem_port_arbiter_priority_pick.sv
// Combinational winner selection: lowest index in fixed mode, or the first requester
// after base_i (wrapping) in round-robin mode.
module arb_priority_pick
  import arb_types::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PTR_W     = ptr_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PTR_W-1:0]     base_i,
  input  arb_mode_t            mode_i,
  output logic [NUM_PORTS-1:0] winner_o,
  output logic                 valid_o
);

  int start_idx;
  int cand_idx;

  always_comb begin
    winner_o  = '0;
    valid_o   = 1'b0;
    start_idx = 0;
    cand_idx  = 0;
    if (mode_i == ARB_RR) begin
      start_idx = int'(base_i) + 1;
      if (start_idx >= NUM_PORTS) start_idx = 0;
    end
    // Walk candidates in priority order; the inner loop keeps all bit selects constant.
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand_idx = start_idx + k;
      if (cand_idx >= NUM_PORTS) cand_idx = cand_idx - NUM_PORTS;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (i == cand_idx && !valid_o && req_i[i]) begin
          winner_o[i] = 1'b1;
          valid_o     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-port arbiter sharing one memory port: registers the winning request onto mem_*,
// holds it until mem_resp, then returns to IDLE for one bubble cycle.
module mem_port_arbiter
  import arb_types::*;
#(
  parameter int        NUM_PORTS  = 2,
  parameter int        ADDR_WIDTH = 32,
  parameter int        DATA_WIDTH = 32,
  parameter arb_mode_t ARB_MODE   = ARB_RR
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus,
  output arb_state_t       state_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int PTR_W = ptr_width(NUM_PORTS);

  arb_state_t            state_q;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic [BE_W-1:0]       mem_be_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [NUM_PORTS-1:0]  grant_q;
  logic [PTR_W-1:0]      grant_idx_q;
  logic [PTR_W-1:0]      rr_ptr_q;
  logic                  busy_q;

  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  win_oh;
  logic                  win_valid;
  logic                  sel_read;
  logic                  sel_write;
  logic [BE_W-1:0]       sel_be;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [PTR_W-1:0]      win_idx_d;

  assign req = bus.port_read | bus.port_write;

  arb_priority_pick #(
    .NUM_PORTS(NUM_PORTS),
    .PTR_W    (PTR_W)
  ) u_pick (
    .req_i   (req),
    .base_i  (rr_ptr_q),
    .mode_i  (ARB_MODE),
    .winner_o(win_oh),
    .valid_o (win_valid)
  );

  always_comb begin
    sel_read  = 1'b0;
    sel_write = 1'b0;
    sel_be    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    win_idx_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (win_oh[i]) begin
        sel_read  = bus.port_read[i];
        sel_write = bus.port_write[i];
        sel_be    = bus.port_byte_enable[i];
        sel_addr  = bus.port_address[i];
        sel_wdata = bus.port_wdata[i];
        win_idx_d = PTR_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      rr_ptr_q    <= PTR_W'(NUM_PORTS - 1);
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (win_valid) begin
            // A port raising both strobes is served as a single write.
            mem_write_q <= sel_write;
            mem_read_q  <= sel_read & ~sel_write;
            mem_be_q    <= sel_be;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            grant_q     <= win_oh;
            grant_idx_q <= win_idx_d;
            busy_q      <= 1'b1;
            state_q     <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (bus.mem_resp) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            state_q     <= ARB_IDLE;
            if (ARB_MODE == ARB_RR) rr_ptr_q <= grant_idx_q;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_read        = mem_read_q;
  assign bus.mem_write       = mem_write_q;
  assign bus.mem_byte_enable = mem_be_q;
  assign bus.mem_address     = mem_addr_q;
  assign bus.mem_wdata       = mem_wdata_q;
  assign bus.grant           = grant_q;
  assign bus.busy            = busy_q;
  assign bus.port_rdata      = bus.mem_rdata;
  assign bus.port_resp       = grant_q & {NUM_PORTS{bus.mem_resp & busy_q}};
  assign state_o             = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a 2-port fixed-priority instance and a 3-port round-robin
// instance, driven by random clients and a random-latency memory, checked by a transaction model.
module tb_mem_port_arbiter;
  import arb_types::*;

  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_fx ();
  mem_port_arbiter_if #(.NUM_PORTS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_rr ();
  arb_state_t st_fx;
  arb_state_t st_rr;

  mem_port_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(ARB_FIXED))
    dut_fx (.clk(clk), .rst(rst), .bus(if_fx.slave), .state_o(st_fx));
  mem_port_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(ARB_RR))
    dut_rr (.clk(clk), .rst(rst), .bus(if_rr.slave), .state_o(st_rr));

  // index 0 = fixed instance, index 1 = round-robin instance
  logic [NP-1:0] b_read[2];
  logic [NP-1:0] b_write[2];
  logic [BW-1:0] b_be[2][NP];
  logic [AW-1:0] b_addr[2][NP];
  logic [DW-1:0] b_wdata[2][NP];
  logic          b_mresp[2];
  logic [DW-1:0] b_mrdata[2];

  logic [NP-1:0] o_grant[2];
  logic [NP-1:0] o_resp[2];
  logic          o_mread[2];
  logic          o_mwrite[2];
  logic          o_busy[2];
  logic [BW-1:0] o_mbe[2];
  logic [AW-1:0] o_maddr[2];
  logic [DW-1:0] o_mwdata[2];
  logic [DW-1:0] o_rdata[2];

  assign if_fx.port_read        = b_read[0][1:0];
  assign if_fx.port_write       = b_write[0][1:0];
  assign if_fx.port_byte_enable = {b_be[0][1], b_be[0][0]};
  assign if_fx.port_address     = {b_addr[0][1], b_addr[0][0]};
  assign if_fx.port_wdata       = {b_wdata[0][1], b_wdata[0][0]};
  assign if_fx.mem_rdata        = b_mrdata[0];
  assign if_fx.mem_resp         = b_mresp[0];
  assign o_grant[0]  = {1'b0, if_fx.grant};
  assign o_resp[0]   = {1'b0, if_fx.port_resp};
  assign o_mread[0]  = if_fx.mem_read;
  assign o_mwrite[0] = if_fx.mem_write;
  assign o_busy[0]   = if_fx.busy;
  assign o_mbe[0]    = if_fx.mem_byte_enable;
  assign o_maddr[0]  = if_fx.mem_address;
  assign o_mwdata[0] = if_fx.mem_wdata;
  assign o_rdata[0]  = if_fx.port_rdata;

  assign if_rr.port_read        = b_read[1];
  assign if_rr.port_write       = b_write[1];
  assign if_rr.port_byte_enable = {b_be[1][2], b_be[1][1], b_be[1][0]};
  assign if_rr.port_address     = {b_addr[1][2], b_addr[1][1], b_addr[1][0]};
  assign if_rr.port_wdata       = {b_wdata[1][2], b_wdata[1][1], b_wdata[1][0]};
  assign if_rr.mem_rdata        = b_mrdata[1];
  assign if_rr.mem_resp         = b_mresp[1];
  assign o_grant[1]  = if_rr.grant;
  assign o_resp[1]   = if_rr.port_resp;
  assign o_mread[1]  = if_rr.mem_read;
  assign o_mwrite[1] = if_rr.mem_write;
  assign o_busy[1]   = if_rr.busy;
  assign o_mbe[1]    = if_rr.mem_byte_enable;
  assign o_maddr[1]  = if_rr.mem_address;
  assign o_mwdata[1] = if_rr.mem_wdata;
  assign o_rdata[1]  = if_rr.port_rdata;

  // transaction-level reference model state
  int            np[2];
  bit            m_busy[2];
  bit            m_first[2];
  int            m_port[2];
  bit            m_rd[2];
  bit            m_wr[2];
  logic [BW-1:0] m_be[2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_wdata[2];
  int            m_last[2];
  int            m_cnt[2];
  int            m_lat[2];
  int            n_txn[2];
  int            wait_txn[2][NP];
  int            lat_lo;
  int            lat_hi;
  int            req_pct;

  // scoreboard
  int         n_checks;
  int         n_pass;
  int         obs_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int model_pick(input int d, input logic [NP-1:0] req);
    if (d == 0) begin
      for (int p = 0; p < np[0]; p++) if (req[p]) return p;
      return -1;
    end
    for (int k = 1; k <= np[d]; k++) begin
      int p;
      p = (m_last[d] + k) % np[d];
      if (req[p]) return p;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [NP-1:0] v);
    int cnt;
    int idx;
    cnt = 0;
    idx = -1;
    for (int i = 0; i < NP; i++) if (v[i]) begin cnt++; idx = i; end
    return (cnt == 1) ? idx : -1;
  endfunction

  // driver tasks
  task automatic set_req(input int d, input int p, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] wd);
    b_read[d][p]  = rd;
    b_write[d][p] = wr;
    b_addr[d][p]  = a;
    b_be[d][p]    = be;
    b_wdata[d][p] = wd;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0;
      m_last[d] = np[d] - 1;
      for (int p = 0; p < NP; p++) wait_txn[d][p] = 0;
    end
  endtask

  task automatic tick(input int d, input bit auto_cl);
    int            resp_port;
    int            w;
    int            rw;
    logic [NP-1:0] req;
    resp_port = -1;
    @(negedge clk);
    check("rdata_bcast", o_rdata[d], b_mrdata[d]);
    if (!m_busy[d]) begin
      check("idle_grant", o_grant[d], 0);
      check("idle_strobes", {o_mread[d], o_mwrite[d]}, 0);
      check("idle_busy", o_busy[d], 0);
      check("idle_resp", o_resp[d], 0);
      req = b_read[d] | b_write[d];
      w = model_pick(d, req);
      if (w >= 0) begin
        m_busy[d]  = 1'b1;
        m_first[d] = 1'b1;
        m_port[d]  = w;
        m_wr[d]    = b_write[d][w];
        m_rd[d]    = b_read[d][w] & ~b_write[d][w];
        m_be[d]    = b_be[d][w];
        m_addr[d]  = b_addr[d][w];
        m_wdata[d] = b_wdata[d][w];
        m_cnt[d]   = 0;
        m_lat[d]   = $urandom_range(lat_hi, lat_lo);
        if (d == 1) begin
          check("rr_starve", wait_txn[d][w] < np[d], 1);
          for (int p = 0; p < np[d]; p++) if (p != w && req[p]) wait_txn[d][p]++;
          wait_txn[d][w] = 0;
        end
      end
    end else begin
      check("grant", o_grant[d], 1 << m_port[d]);
      check("strobes", {o_mread[d], o_mwrite[d]}, {m_rd[d], m_wr[d]});
      check("mem_be", o_mbe[d], m_be[d]);
      check("mem_addr", o_maddr[d], m_addr[d]);
      check("mem_wdata", o_mwdata[d], m_wdata[d]);
      check("busy", o_busy[d], 1);
      if (m_first[d]) begin
        obs_q.push_back(oh_idx(o_grant[d]));
        m_first[d] = 1'b0;
      end
      if (b_mresp[d]) begin
        check("port_resp", o_resp[d], 1 << m_port[d]);
        m_busy[d] = 1'b0;
        m_last[d] = m_port[d];
        resp_port = m_port[d];
        n_txn[d]++;
      end else begin
        check("no_resp", o_resp[d], 0);
      end
    end
    @(posedge clk);
    #1;
    if (resp_port >= 0) begin
      b_read[d][resp_port]  = 1'b0;
      b_write[d][resp_port] = 1'b0;
    end
    if (auto_cl) begin
      for (int p = 0; p < np[d]; p++) begin
        if (!(b_read[d][p] | b_write[d][p]) && $urandom_range(99, 0) < req_pct) begin
          rw = $urandom_range(2, 0);
          set_req(d, p, rw != 1, rw != 0, $urandom(), BW'($urandom()), $urandom());
        end
      end
    end
    b_mrdata[d] = $urandom();
    if (m_busy[d]) begin
      b_mresp[d] = (m_cnt[d] == m_lat[d]);
      m_cnt[d]++;
    end else begin
      b_mresp[d] = ($urandom_range(7, 0) == 0);
    end
  endtask

  task automatic drain(input int d);
    int guard;
    guard = 0;
    while ((m_busy[d] || (b_read[d] | b_write[d]) != 0) && guard < 400) begin
      tick(d, 1'b0);
      guard++;
    end
    check("drain_done", guard < 400, 1);
    b_mresp[d] = 1'b0;
  endtask

  task automatic check_order(input string tag);
    for (int i = 0; i < exp_q.size(); i++)
      check(tag, (i < obs_q.size()) ? obs_q[i] : -1, exp_q[i]);
  endtask

  task automatic check_reset_state(input int d);
    check("rst_grant", o_grant[d], 0);
    check("rst_busy", o_busy[d], 0);
    check("rst_strobes", {o_mread[d], o_mwrite[d]}, 0);
    check("rst_addr", o_maddr[d], 0);
    check("rst_wdata", o_mwdata[d], 0);
    check("rst_be", o_mbe[d], 0);
    check("rst_resp", o_resp[d], 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    np[0] = 2;
    np[1] = 3;
    n_checks = 0;
    n_pass = 0;
    for (int d = 0; d < 2; d++) begin
      b_read[d] = '0;
      b_write[d] = '0;
      b_mresp[d] = 1'b0;
      b_mrdata[d] = '0;
      n_txn[d] = 0;
      for (int p = 0; p < NP; p++) set_req(d, p, 1'b0, 1'b0, '0, '0, '0);
    end
    lat_lo = 0;
    lat_hi = 4;
    req_pct = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_state(0);
    check_reset_state(1);
    check("rst_state_fx", st_fx, ARB_IDLE);
    check("rst_state_rr", st_rr, ARB_IDLE);

    // fixed: port0 read 0x100 and port1 write 0x200 together, memory answers 3 cycles late
    @(posedge clk);
    #1;
    lat_lo = 3;
    lat_hi = 3;
    obs_q.delete();
    set_req(0, 0, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
    set_req(0, 1, 1'b0, 1'b1, 32'h200, 4'hF, 32'hCAFE_F00D);
    drain(0);
    exp_q = '{8'd0, 8'd1};
    check_order("fx_order");

    // read+write on one port collapses to a single write
    guard = n_txn[0];
    lat_lo = 2;
    lat_hi = 2;
    set_req(0, 0, 1'b1, 1'b1, 32'h300, 4'h3, 32'h1234_5678);
    drain(0);
    check("rw_one_txn", n_txn[0] - guard, 1);

    // read path on port1
    set_req(0, 1, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
    drain(0);

    // random traffic, fixed priority
    lat_lo = 0;
    lat_hi = 4;
    req_pct = 30;
    repeat (300) tick(0, 1'b1);
    drain(0);

    // round-robin: all ports requesting continuously
    lat_lo = 1;
    lat_hi = 1;
    req_pct = 100;
    obs_q.delete();
    guard = 0;
    while (obs_q.size() < 6 && guard < 100) begin
      tick(1, 1'b1);
      guard++;
    end
    check("rr_seq_timeout", guard < 100, 1);
    drain(1);
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
    check_order("rr_order");

    // random traffic, round-robin, including long stalls
    lat_lo = 0;
    lat_hi = 10;
    req_pct = 30;
    repeat (400) tick(1, 1'b1);
    drain(1);

    // 10-cycle stall with a second requester waiting
    lat_lo = 10;
    lat_hi = 10;
    set_req(1, 0, 1'b1, 1'b0, 32'hA000, 4'h5, 32'h5555_AAAA);
    set_req(1, 1, 1'b0, 1'b1, 32'hB000, 4'hC, 32'h0F0F_0F0F);
    drain(1);

    // reset in the middle of a transaction
    lat_lo = 2;
    lat_hi = 2;
    set_req(1, 1, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
    drain(1);
    lat_lo = 20;
    lat_hi = 20;
    set_req(1, 2, 1'b1, 1'b0, 32'h80, 4'h0, 32'h0);
    repeat (3) tick(1, 1'b0);
    rst = 1'b1;
    b_read[1] = '0;
    b_write[1] = '0;
    b_mresp[1] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    b_mresp[1] = 1'b1;
    @(negedge clk);
    check_reset_state(1);
    check("rst_state_mid", st_rr, ARB_IDLE);
    @(posedge clk);
    #1;
    b_mresp[1] = 1'b0;
    lat_lo = 1;
    lat_hi = 1;
    obs_q.delete();
    for (int p = 0; p < NP; p++) set_req(1, p, 1'b1, 1'b0, 32'h1000 + p, 4'h0, 32'h0);
    drain(1);
    exp_q = '{8'd0};
    check_order("post_rst_first");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
